regfile_stream_port: RTL and testbench

- Command-driven streaming front end for the multi-port register file.
- LOAD command: accepts a valid/ready word stream and drives one register-file write port at consecutive indices.
- DUMP command: drives one combinational register-file read port at consecutive indices and returns the words on a valid/ready output stream with a last flag.
- Used to preload or inspect architectural state at runtime instead of relying on file initialisation.

---
 rtl/regfile_stream_port.sv | 158 +++++++++++++++
 tb/tb_regfile_stream_port.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_stream_port.sv
// Streaming front end for a multi-port register file.
// LOAD turns a valid/ready word stream into writes at consecutive indices.
// DUMP reads consecutive indices through a combinational read port and returns
// them on a registered valid/ready stream with a last flag.
module regfile_stream_port #(
    parameter int width = 1,
    parameter int n     = 1,
    parameter int size  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [n-1:0]     cmd_base,
    input  logic [n:0]       cmd_count,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] in_data,
    output logic             wr_en,
    output logic [n-1:0]     wr_index,
    output logic [width-1:0] wr_data,
    output logic [n-1:0]     rd_req,
    input  logic [width-1:0] rd_resp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DUMP = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam logic [n-1:0] LAST_IDX = n'(size - 1);
    localparam logic [n:0]   REM_ONE  = (n + 1)'(1);

    state_t           state_q, state_d;
    logic [n-1:0]     ptr_q, ptr_d;
    logic [n:0]       rem_q, rem_d;
    logic [width-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             fetch;

    // Indices at or beyond the last entry wrap to 0, so an out-of-range base
    // is used once as given and then folds back into the file.
    function automatic logic [n-1:0] next_ptr(input logic [n-1:0] p);
        return (p >= LAST_IDX) ? '0 : p + n'(1);
    endfunction

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FIN);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

    // State register, transfer pointer/count and the dump output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            rem_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // Next-state logic plus the combinational write/read port drive.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        in_ready    = 1'b0;
        wr_en       = 1'b0;
        wr_index    = '0;
        wr_data     = '0;
        rd_req      = '0;
        fetch       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    ptr_d = cmd_base;
                    rem_d = cmd_count;
                    if (cmd_count == '0) begin
                        state_d = S_FIN;
                    end else if (cmd_op) begin
                        state_d = S_DUMP;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end

            S_LOAD: begin
                // Writes go straight to the file; it commits on this edge.
                in_ready = 1'b1;
                wr_index = ptr_q;
                wr_data  = in_data;
                if (in_valid) begin
                    wr_en = 1'b1;
                    ptr_d = next_ptr(ptr_q);
                    rem_d = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_d = S_FIN;
                    end
                end
            end

            S_DUMP: begin
                rd_req = ptr_q;
                fetch  = (rem_q != '0) && (!out_valid_q || out_ready);
                if (fetch) begin
                    // Capture the word now so later writes to this index
                    // do not disturb a stalled output.
                    out_data_d  = rd_resp;
                    out_valid_d = 1'b1;
                    out_last_d  = (rem_q == REM_ONE);
                    ptr_d       = next_ptr(ptr_q);
                    rem_d       = rem_q - REM_ONE;
                end else if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
                if (out_valid_q && out_ready && out_last_q) begin
                    state_d = S_FIN;
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_stream_port.sv
// Directed bench for regfile_stream_port. Two instances share the stimulus:
// dut_a has 8 entries, dut_b has 6 entries (for the wrap case). Each has its
// own small register-file model that is preloaded with i*0x11 during reset.
module tb_regfile_stream_port;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_op;
    logic [2:0] cmd_base;
    logic [3:0] cmd_count;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic       cmd_ready_a, in_ready_a, wr_en_a, out_valid_a, out_last_a, busy_a, done_a;
    logic [2:0] wr_index_a, rd_req_a;
    logic [7:0] wr_data_a, rd_resp_a, out_data_a;
    logic       cmd_ready_b, in_ready_b, wr_en_b, out_valid_b, out_last_b, busy_b, done_b;
    logic [2:0] wr_index_b, rd_req_b;
    logic [7:0] wr_data_b, rd_resp_b, out_data_b;

    logic [7:0] mem_a [0:7];
    logic [7:0] mem_b [0:5];

    int checks = 0;
    int errors = 0;

    // Expected per-cycle DUMP behaviour for base 6, count 4 on 8 entries.
    logic       rdy_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       vld_exp [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0] dat_exp [7] = '{8'h00, 8'h66, 8'h66, 8'h66, 8'h77, 8'h00, 8'h11};
    logic       lst_exp [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] ld_data [3] = '{8'hA1, 8'hB2, 8'hC3};
    logic [2:0] ld_idx  [3] = '{3'd2, 3'd3, 3'd4};
    logic [2:0] wrap_idx [4] = '{3'd4, 3'd5, 3'd0, 3'd1};

    regfile_stream_port #(.width(8), .n(3), .size(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_a), .cmd_op(cmd_op),
        .cmd_base(cmd_base), .cmd_count(cmd_count),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .wr_en(wr_en_a), .wr_index(wr_index_a), .wr_data(wr_data_a),
        .rd_req(rd_req_a), .rd_resp(rd_resp_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_last(out_last_a), .busy(busy_a), .done(done_a)
    );

    regfile_stream_port #(.width(8), .n(3), .size(6)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_b), .cmd_op(cmd_op),
        .cmd_base(cmd_base), .cmd_count(cmd_count),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .wr_en(wr_en_b), .wr_index(wr_index_b), .wr_data(wr_data_b),
        .rd_req(rd_req_b), .rd_resp(rd_resp_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_last(out_last_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file models: preload while reset is held, otherwise commit writes.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) mem_a[i] <= 8'(i * 17);
        end else if (wr_en_a) begin
            mem_a[wr_index_a] <= wr_data_a;
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) mem_b[i] <= 8'(i * 17);
        end else if (wr_en_b && (wr_index_b < 3'd6)) begin
            mem_b[wr_index_b] <= wr_data_b;
        end
    end

    assign rd_resp_a = mem_a[rd_req_a];
    assign rd_resp_b = (rd_req_b < 3'd6) ? mem_b[rd_req_b] : 8'h00;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_base  = 3'd0;
        cmd_count = 4'd0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        #1;
        chk("reset_cmd_ready", cmd_ready_a, 1);
        chk("reset_busy", busy_a, 0);
        chk("reset_out_valid", out_valid_a, 0);
        chk("reset_wr_en", wr_en_a, 0);
        chk("reset_done", done_a, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // DUMP with backpressure: base 6, count 4 on 8 entries.
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_base = 3'd6; cmd_count = 4'd4;
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("dump_rd_req_first", rd_req_a, 6);
        chk("dump_busy", busy_a, 1);
        for (int k = 0; k < 7; k++) begin
            out_ready = rdy_pat[k];
            #1;
            chk($sformatf("dump_valid_c%0d", k), out_valid_a, vld_exp[k]);
            if (vld_exp[k]) begin
                chk($sformatf("dump_data_c%0d", k), out_data_a, dat_exp[k]);
                chk($sformatf("dump_last_c%0d", k), out_last_a, lst_exp[k]);
            end
            tick();
        end
        out_ready = 1'b0;
        #1;
        chk("dump_done", done_a, 1);
        chk("dump_fin_valid", out_valid_a, 0);
        chk("dump_fin_last", out_last_a, 0);
        tick();
        chk("dump_after_done", done_a, 0);
        chk("dump_after_ready", cmd_ready_a, 1);

        // Asynchronous reset in the middle of a DUMP.
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_base = 3'd1; cmd_count = 4'd3;
        tick();
        cmd_valid = 1'b0;
        tick();
        #1;
        chk("mid_dump_valid", out_valid_a, 1);
        chk("mid_dump_data", out_data_a, 8'h11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid_a, 0);
        chk("async_rst_data", out_data_a, 0);
        chk("async_rst_cmd_ready", cmd_ready_a, 1);
        chk("async_rst_busy", busy_a, 0);
        chk("async_rst_rd_req", rd_req_a, 0);
        tick();
        rst_n = 1'b1;

        // Basic LOAD: base 2, count 3, in_valid held high.
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_base = 3'd2; cmd_count = 4'd3;
        #1;
        chk("load_idle_ready", cmd_ready_a, 1);
        chk("load_idle_wr_en", wr_en_a, 0);
        tick();
        cmd_valid = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = ld_data[k];
            #1;
            chk($sformatf("load_wr_en_%0d", k), wr_en_a, 1);
            chk($sformatf("load_index_%0d", k), wr_index_a, ld_idx[k]);
            chk($sformatf("load_data_%0d", k), wr_data_a, ld_data[k]);
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("load_done", done_a, 1);
        chk("load_fin_wr_en", wr_en_a, 0);
        chk("load_mem2", mem_a[2], 8'hA1);
        chk("load_mem4", mem_a[4], 8'hC3);
        tick();
        chk("load_after_done", done_a, 0);

        // LOAD with stalls and wrap on 6 entries: base 4, count 4.
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_base = 3'd4; cmd_count = 4'd4;
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            in_valid = ((k % 2) == 0);
            in_data  = 8'hD0 + 8'(k / 2);
            #1;
            chk($sformatf("wrap_wr_en_c%0d", k), wr_en_b, ((k % 2) == 0) ? 1 : 0);
            if ((k % 2) == 0) begin
                chk($sformatf("wrap_index_c%0d", k), wr_index_b, wrap_idx[k / 2]);
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("wrap_done", done_b, 1);
        chk("wrap_mem0", mem_b[0], 8'hD2);
        chk("wrap_mem1", mem_b[1], 8'hD3);
        tick();

        // Zero-count LOAD: in_valid high but no write may occur.
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_base = 3'd3; cmd_count = 4'd0;
        in_valid = 1'b1; in_data = 8'h55;
        #1;
        chk("zload_idle_wr_en", wr_en_a, 0);
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("zload_done", done_a, 1);
        chk("zload_wr_en", wr_en_a, 0);
        chk("zload_in_ready", in_ready_a, 0);
        tick();
        in_valid = 1'b0;
        #1;
        chk("zload_after_done", done_a, 0);
        chk("zload_cmd_ready", cmd_ready_a, 1);

        // Zero-count DUMP.
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_base = 3'd3; cmd_count = 4'd0;
        out_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("zdump_done", done_a, 1);
        chk("zdump_valid", out_valid_a, 0);
        tick();
        chk("zdump_cmd_ready", cmd_ready_a, 1);
        chk("zdump_after_valid", out_valid_a, 0);
        out_ready = 1'b0;

        // cmd_valid held through a LOAD: second command waits for FIN.
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_base = 3'd0; cmd_count = 4'd2;
        in_valid = 1'b1; in_data = 8'hE0;
        tick();
        #1;
        chk("hold_busy_0", busy_a, 1);
        chk("hold_cmd_ready_0", cmd_ready_a, 0);
        chk("hold_index_0", wr_index_a, 0);
        chk("hold_data_0", wr_data_a, 8'hE0);
        tick();
        in_data = 8'hE1;
        #1;
        chk("hold_busy_1", busy_a, 1);
        chk("hold_index_1", wr_index_a, 1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("hold_done", done_a, 1);
        chk("hold_busy_fin", busy_a, 1);
        chk("hold_cmd_ready_fin", cmd_ready_a, 0);
        tick();
        chk("hold_idle_ready", cmd_ready_a, 1);
        chk("hold_idle_busy", busy_a, 0);
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("hold_second_busy", busy_a, 1);
        chk("hold_second_in_ready", in_ready_a, 1);
        chk("hold_second_wr_en", wr_en_a, 0);
        in_valid = 1'b1; in_data = 8'hF0;
        tick();
        in_data = 8'hF1;
        tick();
        in_valid = 1'b0;
        #1;
        chk("hold_second_done", done_a, 1);
        chk("hold_second_mem1", mem_a[1], 8'hF1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
